// File: rtl/ysyx_22041207_axi_read_master.sv
// ysyx_22041207_axi_read_master: single-outstanding AXI4 read master; arbiter-side r_* request/data ports in, single-beat axi_ar_*/axi_r_* out, right-justified size-masked data back
module ysyx_22041207_axi_read_master #(
  parameter int RW_DATA_WIDTH  = 64,
  parameter int RW_ADDR_WIDTH  = 64,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_ID         = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      r_valid_i,
  output logic                      r_ready_o,
  input  logic [RW_ADDR_WIDTH-1:0]  r_addr_i,
  input  logic [7:0]                r_size_i,
  output logic [RW_DATA_WIDTH-1:0]  data_read_o,
  output logic                      r_data_valid_o,
  input  logic                      r_data_ready_i,
  output logic                      r_err_o,
  output logic                      axi_ar_valid_o,
  input  logic                      axi_ar_ready_i,
  output logic [AXI_ADDR_WIDTH-1:0] axi_ar_addr_o,
  output logic [AXI_ID_WIDTH-1:0]   axi_ar_id_o,
  output logic [7:0]                axi_ar_len_o,
  output logic [2:0]                axi_ar_size_o,
  output logic [1:0]                axi_ar_burst_o,
  input  logic                      axi_r_valid_i,
  output logic                      axi_r_ready_o,
  input  logic [AXI_DATA_WIDTH-1:0] axi_r_data_i,
  input  logic [1:0]                axi_r_resp_i,
  input  logic                      axi_r_last_i,
  input  logic [AXI_ID_WIDTH-1:0]   axi_r_id_i
);
  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_DONE} state_t;
  state_t r_state, w_next;
  logic [RW_ADDR_WIDTH-1:0] r_addr;
  logic [7:0] r_size;
  logic [RW_DATA_WIDTH-1:0] r_data, w_shift, w_proc;
  logic r_err, w_beat;
  assign w_beat = r_state == S_R && axi_r_valid_i && axi_r_id_i == AXI_ID_WIDTH'(AXI_ID);
  assign w_shift = RW_DATA_WIDTH'(axi_r_data_i >> {r_addr[2:0], 3'b000});
  assign w_proc = r_size == 8'd1 ? RW_DATA_WIDTH'(w_shift[7:0]) :
                  r_size == 8'd2 ? RW_DATA_WIDTH'(w_shift[15:0]) :
                  r_size == 8'd4 ? RW_DATA_WIDTH'(w_shift[31:0]) : w_shift;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb
    w_next = r_state == S_IDLE ? (r_valid_i ? S_AR : S_IDLE) :
             r_state == S_AR   ? (axi_ar_ready_i ? S_R : S_AR) :
             r_state == S_R    ? (w_beat && axi_r_last_i ? S_DONE : S_R) :
                                 (r_data_ready_i ? S_IDLE : S_DONE);
  always_comb begin
    r_ready_o      = r_state == S_IDLE && r_valid_i;
    axi_ar_valid_o = r_state == S_AR;
    axi_r_ready_o  = r_state == S_R;
    r_data_valid_o = r_state == S_DONE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_addr <= '0;
      r_size <= '0;
      r_data <= '0;
      r_err  <= 1'b0;
    end else begin
      if (r_ready_o) begin
        r_addr <= r_addr_i;
        r_size <= r_size_i;
      end
      if (w_beat) begin
        r_data <= w_proc;
        r_err  <= axi_r_resp_i != 2'b00;
      end else if (r_state == S_DONE && r_data_ready_i) r_err <= 1'b0;
    end
  assign data_read_o    = r_data;
  assign r_err_o        = r_err;
  assign axi_ar_addr_o  = AXI_ADDR_WIDTH'(r_addr);
  assign axi_ar_id_o    = AXI_ID_WIDTH'(AXI_ID);
  assign axi_ar_len_o   = 8'd0;
  assign axi_ar_burst_o = 2'b01;
  assign axi_ar_size_o  = r_size == 8'd1 ? 3'd0 : r_size == 8'd2 ? 3'd1 : r_size == 8'd4 ? 3'd2 : 3'd3;
endmodule
